// File: rtl/arbitro_mem_buses.sv
// Round-robin arbiter granting the shared memory port to one of CANTIDAD_BUSES window buses.
// Skips idle buses, hands over back-to-back on release, and forces rotation at the burst limit.
module arbitro_mem_buses #(
    parameter int CANTIDAD_BUSES = 4,
    parameter int BITS_DATOS     = 2,
    parameter int MAX_RAFAGA     = 16,
    parameter int BITS_RAFAGA    = 5
) (
    input  logic                      clk,
    input  logic                      reset,
    input  logic [CANTIDAD_BUSES-1:0] solicitudes,
    input  logic                      liberar,
    output logic                      concedido,
    output logic [BITS_DATOS-1:0]     bus_actual,
    output logic [CANTIDAD_BUSES-1:0] concesion,
    output logic [BITS_DATOS-1:0]     bus_siguiente
);

    typedef enum logic {REPOSO, OTORGADO} estado_t;

    localparam logic [BITS_DATOS-1:0]  ULTIMO        = BITS_DATOS'(CANTIDAD_BUSES - 1);
    localparam logic [BITS_RAFAGA-1:0] RAFAGA_TOPE   = BITS_RAFAGA'(MAX_RAFAGA);
    localparam logic [BITS_RAFAGA-1:0] RAFAGA_LIMITE = BITS_RAFAGA'(MAX_RAFAGA - 1);

    estado_t                   estado;
    logic [BITS_DATOS-1:0]     puntero;
    logic [BITS_RAFAGA-1:0]    rafaga;
    logic [BITS_DATOS-1:0]     dueno_mas_uno;
    logic [BITS_DATOS-1:0]     inicio;
    logic                      hallado;
    logic                      dueno_pide;
    logic                      otros;
    logic                      rotar;
    logic [CANTIDAD_BUSES-1:0] one_hot_sig;

    // While granted, the lookahead search starts just past the owner, which is
    // exactly where a rotation would move the pointer.
    always_comb begin
        dueno_mas_uno = (bus_actual == ULTIMO) ? '0 : bus_actual + BITS_DATOS'(1);
        inicio        = (estado == OTORGADO) ? dueno_mas_uno : puntero;
    end

    // Two passes give the wrap-around scan: [inicio, N-1] first, then [0, inicio-1].
    always_comb begin
        hallado       = 1'b0;
        bus_siguiente = puntero;
        for (int j = 0; j < CANTIDAD_BUSES; j++) begin
            if (!hallado && solicitudes[j] && (j >= int'(inicio))) begin
                hallado       = 1'b1;
                bus_siguiente = BITS_DATOS'(j);
            end
        end
        for (int j = 0; j < CANTIDAD_BUSES; j++) begin
            if (!hallado && solicitudes[j] && (j < int'(inicio))) begin
                hallado       = 1'b1;
                bus_siguiente = BITS_DATOS'(j);
            end
        end
    end

    always_comb begin
        one_hot_sig = '0;
        for (int j = 0; j < CANTIDAD_BUSES; j++) begin
            if (bus_siguiente == BITS_DATOS'(j)) begin
                one_hot_sig[j] = 1'b1;
            end
        end
        dueno_pide = |(solicitudes & concesion);
        otros      = |(solicitudes & ~concesion);
        // A saturated counter still forces rotation once a competitor shows up.
        rotar      = liberar || !dueno_pide || ((rafaga >= RAFAGA_LIMITE) && otros);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            estado     <= REPOSO;
            puntero    <= '0;
            rafaga     <= '0;
            bus_actual <= '0;
            concedido  <= 1'b0;
            concesion  <= '0;
        end else begin
            case (estado)
                REPOSO: begin
                    if (hallado) begin
                        estado     <= OTORGADO;
                        bus_actual <= bus_siguiente;
                        concesion  <= one_hot_sig;
                        concedido  <= 1'b1;
                        rafaga     <= '0;
                    end
                end
                OTORGADO: begin
                    if (rotar) begin
                        puntero <= dueno_mas_uno;
                        rafaga  <= '0;
                        if (hallado) begin
                            bus_actual <= bus_siguiente;
                            concesion  <= one_hot_sig;
                        end else begin
                            estado    <= REPOSO;
                            concedido <= 1'b0;
                            concesion <= '0;
                        end
                    end else if (rafaga != RAFAGA_TOPE) begin
                        rafaga <= rafaga + BITS_RAFAGA'(1);
                    end
                end
                default: begin
                    estado <= REPOSO;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_arbitro_mem_buses.sv
// Directed bench for arbitro_mem_buses: a 4-bus instance with a burst limit of 4
// and a 3-bus instance with default burst limit, both with hand-computed expectations.
module tb_arbitro_mem_buses;

    logic       clk = 1'b0;
    logic       reset;
    logic [3:0] sol4;
    logic       lib4;
    logic       concedido4;
    logic [1:0] bus_actual4;
    logic [3:0] concesion4;
    logic [1:0] bus_siguiente4;
    logic [2:0] sol3;
    logic       lib3;
    logic       concedido3;
    logic [1:0] bus_actual3;
    logic [2:0] concesion3;
    logic [1:0] bus_siguiente3;

    int n_compared   = 0;
    int n_mismatched = 0;

    always #5 clk = ~clk;

    arbitro_mem_buses #(
        .CANTIDAD_BUSES(4), .BITS_DATOS(2), .MAX_RAFAGA(4), .BITS_RAFAGA(3)
    ) u_dut4 (
        .clk(clk), .reset(reset), .solicitudes(sol4), .liberar(lib4),
        .concedido(concedido4), .bus_actual(bus_actual4),
        .concesion(concesion4), .bus_siguiente(bus_siguiente4)
    );

    arbitro_mem_buses #(
        .CANTIDAD_BUSES(3), .BITS_DATOS(2), .MAX_RAFAGA(16), .BITS_RAFAGA(5)
    ) u_dut3 (
        .clk(clk), .reset(reset), .solicitudes(sol3), .liberar(lib3),
        .concedido(concedido3), .bus_actual(bus_actual3),
        .concesion(concesion3), .bus_siguiente(bus_siguiente3)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        if (obs !== exp) begin
            n_mismatched++;
            $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_grant4(input string tag, input int own);
        check({tag, ".concedido"}, 32'(concedido4), 32'd1);
        check({tag, ".bus_actual"}, 32'(bus_actual4), 32'(own));
        check({tag, ".concesion"}, 32'(concesion4), 32'(1 << own));
    endtask

    task automatic check_idle4(input string tag, input int last_owner);
        check({tag, ".concedido"}, 32'(concedido4), 32'd0);
        check({tag, ".concesion"}, 32'(concesion4), 32'd0);
        check({tag, ".bus_actual"}, 32'(bus_actual4), 32'(last_owner));
    endtask

    initial begin
        reset = 1'b1;
        sol4  = '0;
        lib4  = 1'b0;
        sol3  = '0;
        lib3  = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_idle4("reset", 0);
        check("reset.siguiente", 32'(bus_siguiente4), 32'd0);

        // Grant from idle, then reset mid-grant
        sol4 = 4'b0100;
        #1;
        check("idle.siguiente", 32'(bus_siguiente4), 32'd2);
        tick();
        check_grant4("first_grant", 2);
        reset = 1'b1;
        sol4  = '0;
        tick();
        reset = 1'b0;
        check_idle4("reset_mid_grant", 0);

        // Round robin with a release every third cycle: 0,1,2,3,0
        sol4 = 4'b1111;
        tick();
        for (int k = 0; k < 4; k++) begin
            check_grant4($sformatf("rr%0d.c0", k), k);
            tick();
            check_grant4($sformatf("rr%0d.c1", k), k);
            tick();
            check_grant4($sformatf("rr%0d.c2", k), k);
            lib4 = 1'b1;
            tick();
            lib4 = 1'b0;
        end
        check_grant4("rr_wrap", 0);

        // Burst limit: bus 1 holds 4 cycles while bus 3 waits
        sol4 = 4'b1010;
        tick();
        check_grant4("burst.c0", 1);
        for (int k = 1; k < 4; k++) begin
            tick();
            check_grant4($sformatf("burst.c%0d", k), 1);
        end
        tick();
        check_grant4("burst.rotated", 3);

        // Bus 1 alone keeps the grant
        sol4 = 4'b0010;
        tick();
        check_grant4("alone.c0", 1);
        for (int k = 1; k <= 10; k++) begin
            tick();
            check_grant4($sformatf("alone.c%0d", k), 1);
        end

        // Owner drops its request; idle buses are skipped
        reset = 1'b1;
        sol4  = '0;
        tick();
        reset = 1'b0;
        sol4  = 4'b0100;
        tick();
        check_grant4("drop.own2", 2);
        sol4 = 4'b0001;
        tick();
        check_grant4("drop.skip3", 0);
        sol4 = 4'b0010;
        tick();
        check_grant4("drop.to1", 1);
        sol4 = 4'b0000;
        tick();
        check_idle4("drop.idle", 1);
        check("drop.idle.siguiente", 32'(bus_siguiente4), 32'd2);
        lib4 = 1'b1;
        tick();
        lib4 = 1'b0;
        check_idle4("lib_idle", 1);
        check("lib_idle.siguiente", 32'(bus_siguiente4), 32'd2);
        sol4 = 4'b0101;
        #1;
        check("regrant.siguiente", 32'(bus_siguiente4), 32'd2);
        tick();
        check_grant4("regrant", 2);

        // Release on the burst-limit cycle rotates exactly once
        sol4 = 4'b1111;
        for (int k = 1; k < 4; k++) begin
            tick();
            check_grant4($sformatf("coinc.c%0d", k), 2);
        end
        lib4 = 1'b1;
        tick();
        lib4 = 1'b0;
        check_grant4("coinc.single", 3);
        check("coinc.siguiente", 32'(bus_siguiente4), 32'd0);
        lib4 = 1'b1;
        tick();
        lib4 = 1'b0;
        check_grant4("coinc.next", 0);

        // Three buses: 0,1,2,0,1 with wrap at a non-power-of-two count
        sol3 = 3'b111;
        tick();
        for (int k = 0; k < 5; k++) begin
            check($sformatf("n3.%0d.concedido", k), 32'(concedido3), 32'd1);
            check($sformatf("n3.%0d.bus_actual", k), 32'(bus_actual3), 32'(k % 3));
            check($sformatf("n3.%0d.concesion", k), 32'(concesion3), 32'(1 << (k % 3)));
            lib3 = 1'b1;
            tick();
            lib3 = 1'b0;
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
